// File: rtl/pipeline_hazard_unit_if.sv
// Hazard-unit bundle: pipeline status flowing in, stage control and forwarding selects flowing out.
interface pipeline_hazard_unit_if #(
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned STALL_CNT_W = 16
);
   logic                   debug_en;
   logic                   debug_step;
   logic                   rs_used;
   logic                   rt_used;
   logic [REG_ADDR_W-1:0]  addr_rs;
   logic [REG_ADDR_W-1:0]  addr_rt;
   logic                   branch_id;
   logic [REG_ADDR_W-1:0]  regw_addr_exe;
   logic                   wb_wen_exe;
   logic                   mem_ren_exe;
   logic [REG_ADDR_W-1:0]  regw_addr_mem;
   logic                   wb_wen_mem;
   logic                   mem_req_mem;
   logic                   mem_ready;

   logic                   if_en, id_en, exe_en, mem_en, wb_en;
   logic                   if_rst, id_rst, exe_rst, mem_rst, wb_rst;
   logic [1:0]             fwd_a_sel;
   logic [1:0]             fwd_b_sel;
   logic [STALL_CNT_W-1:0] stall_count;
   logic                   flushing;

   // Pipeline side: drives status, consumes control.
   modport master (
      output debug_en, debug_step, rs_used, rt_used, addr_rs, addr_rt, branch_id,
             regw_addr_exe, wb_wen_exe, mem_ren_exe, regw_addr_mem, wb_wen_mem,
             mem_req_mem, mem_ready,
      input  if_en, id_en, exe_en, mem_en, wb_en,
             if_rst, id_rst, exe_rst, mem_rst, wb_rst,
             fwd_a_sel, fwd_b_sel, stall_count, flushing
   );

   // Hazard unit side.
   modport slave (
      input  debug_en, debug_step, rs_used, rt_used, addr_rs, addr_rt, branch_id,
             regw_addr_exe, wb_wen_exe, mem_ren_exe, regw_addr_mem, wb_wen_mem,
             mem_req_mem, mem_ready,
      output if_en, id_en, exe_en, mem_en, wb_en,
             if_rst, id_rst, exe_rst, mem_rst, wb_rst,
             fwd_a_sel, fwd_b_sel, stall_count, flushing
   );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Five-stage pipeline hazard unit: forwarding/stall detection, branch flush sequencing,
// memory/debug freeze and a saturating stall-cycle counter.
module pipeline_hazard_unit #(
   parameter int unsigned REG_ADDR_W     = 5,
   parameter bit          FWD_EN         = 1'b1,
   parameter int unsigned BRANCH_PENALTY = 3,
   parameter int unsigned STALL_CNT_W    = 16
) (
   input logic                  clk,
   input logic                  rst,
   pipeline_hazard_unit_if.slave hz
);
   localparam int unsigned CNT_W = 3;
   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   logic [0:0]             state_q, state_d;
   logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;
   logic                   debug_step_q;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic [REG_ADDR_W-1:0]  addr_rs, addr_rt;
   logic                   rs_haz, rt_haz;
   logic                   a_exe, a_mem, b_exe, b_mem;
   logic                   step_pulse, freeze, reg_stall, stall_inc;
   logic [1:0]             fwd_a, fwd_b;
   logic [4:0]             en_c, flush_c;

   assign addr_rs = hz.addr_rs;
   assign addr_rt = hz.addr_rt;

   // Register r0 is hardwired zero, so it never creates a dependency.
   assign rs_haz = hz.rs_used && (addr_rs != '0);
   assign rt_haz = hz.rt_used && (addr_rt != '0);
   assign a_exe  = rs_haz && hz.wb_wen_exe && (addr_rs == hz.regw_addr_exe);
   assign a_mem  = rs_haz && hz.wb_wen_mem && (addr_rs == hz.regw_addr_mem);
   assign b_exe  = rt_haz && hz.wb_wen_exe && (addr_rt == hz.regw_addr_exe);
   assign b_mem  = rt_haz && hz.wb_wen_mem && (addr_rt == hz.regw_addr_mem);

   assign step_pulse = hz.debug_step & ~debug_step_q;
   assign freeze     = (hz.mem_req_mem & ~hz.mem_ready) | (hz.debug_en & ~step_pulse);

   // Operand source selection and data-hazard stall request.
   always_comb begin
      fwd_a     = 2'b00;
      fwd_b     = 2'b00;
      reg_stall = 1'b0;
      if (FWD_EN) begin
         if (a_exe && !hz.mem_ren_exe) fwd_a = 2'b01;
         else if (a_mem)               fwd_a = 2'b10;
         if (b_exe && !hz.mem_ren_exe) fwd_b = 2'b01;
         else if (b_mem)               fwd_b = 2'b10;
         reg_stall = (a_exe | b_exe) & hz.mem_ren_exe;
      end else begin
         reg_stall = a_exe | a_mem | b_exe | b_mem;
      end
   end

   // Stage control and flush sequencing; bit order is {if, id, exe, mem, wb}.
   always_comb begin
      en_c        = 5'b11111;
      flush_c     = 5'b00000;
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      if (!rst) begin
         flush_c = 5'b11111;
      end else if (freeze) begin
         en_c = 5'b00000;
      end else if (state_q == ST_FLUSH) begin
         flush_c[3]  = 1'b1;
         flush_cnt_d = flush_cnt_q - CNT_W'(1);
         if (flush_cnt_q == CNT_W'(1)) state_d = ST_RUN;
      end else if (reg_stall) begin
         en_c[4]    = 1'b0;
         en_c[3]    = 1'b0;
         flush_c[2] = 1'b1;
      end else if (hz.branch_id) begin
         flush_c[3] = 1'b1;
         if (BRANCH_PENALTY > 1) begin
            flush_cnt_d = CNT_W'(BRANCH_PENALTY - 1);
            state_d     = ST_FLUSH;
         end
      end
   end

   // Stalls requested during a flush are ignored, so they do not count.
   assign stall_inc = freeze | (reg_stall & (state_q == ST_RUN));

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_RUN;
         flush_cnt_q  <= '0;
         debug_step_q <= 1'b0;
         stall_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         flush_cnt_q  <= flush_cnt_d;
         debug_step_q <= hz.debug_step;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign hz.if_en       = en_c[4];
   assign hz.id_en       = en_c[3];
   assign hz.exe_en      = en_c[2];
   assign hz.mem_en      = en_c[1];
   assign hz.wb_en       = en_c[0];
   assign hz.if_rst      = flush_c[4];
   assign hz.id_rst      = flush_c[3];
   assign hz.exe_rst     = flush_c[2];
   assign hz.mem_rst     = flush_c[1];
   assign hz.wb_rst      = flush_c[0];
   assign hz.fwd_a_sel   = rst ? fwd_a : 2'b00;
   assign hz.fwd_b_sel   = rst ? fwd_b : 2'b00;
   assign hz.stall_count = stall_cnt_q;
   assign hz.flushing    = rst && (state_q == ST_FLUSH);
endmodule
